// File: rtl/mano_datapath.sv
// Mano machine register-transfer datapath: executes one 21-bit control word per clock
// (bus select, register loads/increments, ALU and accumulator micro-ops, memory write, halt).
module mano_datapath #(
    parameter int WORD_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [20:0]       control_reg,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [WORD_W-1:0] ir,
    output logic [WORD_W-1:0] ac,
    output logic [WORD_W-1:0] dr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ar,
    output logic              e,
    output logic              ac_zero,
    output logic              halted,
    output logic              cw_err
);

    logic [ADDR_W-1:0] ar_q, ar_d, pc_q, pc_d;
    logic [WORD_W-1:0] dr_q, dr_d, ac_q, ac_d, ir_q, ir_d;
    logic              e_q, e_d, running_q, running_d, cw_err_q, cw_err_d;
    logic [WORD_W-1:0] bus_s, alu_s;
    logic [WORD_W:0]   sum_s;
    logic [2:0]        bus_sel_s;
    logic [1:0]        alu_op_s;
    logic              rot_r_s, rot_l_s;

    assign bus_sel_s = control_reg[2:0];
    assign alu_op_s  = control_reg[18:17];
    // A simultaneous cir/cil request cancels both rotates.
    assign rot_r_s   = control_reg[15] & ~control_reg[16];
    assign rot_l_s   = control_reg[16] & ~control_reg[15];
    assign sum_s     = {1'b0, ac_q} + {1'b0, dr_q};

    // Common bus source selection
    always_comb begin
        bus_s = {WORD_W{1'b0}};
        case (bus_sel_s)
            3'd1:    bus_s = {{(WORD_W-ADDR_W){1'b0}}, ar_q};
            3'd2:    bus_s = {{(WORD_W-ADDR_W){1'b0}}, pc_q};
            3'd3:    bus_s = dr_q;
            3'd4:    bus_s = ac_q;
            3'd5:    bus_s = ir_q;
            3'd7:    bus_s = mem_rdata;
            default: bus_s = {WORD_W{1'b0}};
        endcase
    end

    // ALU result feeding the accumulator load
    always_comb begin
        alu_s = dr_q;
        case (alu_op_s)
            2'b00:   alu_s = dr_q;
            2'b01:   alu_s = ac_q & dr_q;
            2'b10:   alu_s = sum_s[WORD_W-1:0];
            2'b11:   alu_s = bus_s;
            default: alu_s = dr_q;
        endcase
    end

    // Next-state for every register, honouring per-register priorities and halt
    always_comb begin
        ar_d      = ar_q;
        pc_d      = pc_q;
        dr_d      = dr_q;
        ir_d      = ir_q;
        ac_d      = ac_q;
        e_d       = e_q;
        cw_err_d  = cw_err_q;
        running_d = running_q;
        if (running_q) begin
            if (control_reg[20])      ar_d = {ADDR_W{1'b0}};
            else if (control_reg[3])  ar_d = bus_s[ADDR_W-1:0];
            else                      ar_d = ar_q;

            if (control_reg[4])       pc_d = bus_s[ADDR_W-1:0];
            else if (control_reg[5])  pc_d = pc_q + ADDR_W'(1);
            else                      pc_d = pc_q;

            if (control_reg[6])       dr_d = bus_s;
            else                      dr_d = dr_q;

            if (control_reg[8])       ir_d = bus_s;
            else                      ir_d = ir_q;

            if (control_reg[10])      ac_d = {WORD_W{1'b0}};
            else if (control_reg[7])  ac_d = alu_s;
            else if (control_reg[11]) ac_d = ac_q + WORD_W'(1);
            else if (rot_r_s)         ac_d = {e_q, ac_q[WORD_W-1:1]};
            else if (rot_l_s)         ac_d = {ac_q[WORD_W-2:0], e_q};
            else if (control_reg[14]) ac_d = ~ac_q;
            else                      ac_d = ac_q;

            if (control_reg[12])                          e_d = 1'b0;
            else if (control_reg[7] && alu_op_s == 2'b10) e_d = sum_s[WORD_W];
            else if (rot_r_s)                             e_d = ac_q[0];
            else if (rot_l_s)                             e_d = ac_q[WORD_W-1];
            else if (control_reg[13])                     e_d = ~e_q;
            else                                          e_d = e_q;

            cw_err_d  = cw_err_q | (control_reg[15] & control_reg[16])
                                 | (control_reg[9] & (bus_sel_s == 3'd7));
            running_d = ~control_reg[19];
        end else begin
            running_d = 1'b0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_q      <= {ADDR_W{1'b0}};
            pc_q      <= {ADDR_W{1'b0}};
            dr_q      <= {WORD_W{1'b0}};
            ac_q      <= {WORD_W{1'b0}};
            ir_q      <= {WORD_W{1'b0}};
            e_q       <= 1'b0;
            cw_err_q  <= 1'b0;
            running_q <= 1'b1;
        end else begin
            ar_q      <= ar_d;
            pc_q      <= pc_d;
            dr_q      <= dr_d;
            ac_q      <= ac_d;
            ir_q      <= ir_d;
            e_q       <= e_d;
            cw_err_q  <= cw_err_d;
            running_q <= running_d;
        end
    end

    assign mem_addr  = ar_q;
    assign mem_wdata = bus_s;
    assign mem_we    = control_reg[9] & running_q & ~reset;
    assign ir        = ir_q;
    assign ac        = ac_q;
    assign dr        = dr_q;
    assign pc        = pc_q;
    assign ar        = ar_q;
    assign e         = e_q;
    assign ac_zero   = (ac_q == {WORD_W{1'b0}});
    assign halted    = ~running_q;
    assign cw_err    = cw_err_q;

endmodule

// File: tb/tb_mano_datapath.sv
// Self-checking bench for mano_datapath: directed scenarios plus randomized control
// words, compared each cycle against an arithmetic reference model with its own memory.
module tb_mano_datapath;

    localparam logic [20:0] AR_LD  = 21'd1 << 3;
    localparam logic [20:0] PC_LD  = 21'd1 << 4;
    localparam logic [20:0] PC_INC = 21'd1 << 5;
    localparam logic [20:0] DR_LD  = 21'd1 << 6;
    localparam logic [20:0] AC_LD  = 21'd1 << 7;
    localparam logic [20:0] IR_LD  = 21'd1 << 8;
    localparam logic [20:0] MEM_WE = 21'd1 << 9;
    localparam logic [20:0] AC_CLR = 21'd1 << 10;
    localparam logic [20:0] AC_INC = 21'd1 << 11;
    localparam logic [20:0] E_CLR  = 21'd1 << 12;
    localparam logic [20:0] E_CMP  = 21'd1 << 13;
    localparam logic [20:0] AC_CMP = 21'd1 << 14;
    localparam logic [20:0] CIR    = 21'd1 << 15;
    localparam logic [20:0] CIL    = 21'd1 << 16;
    localparam logic [20:0] OP_AND = 21'd1 << 17;
    localparam logic [20:0] OP_ADD = 21'd2 << 17;
    localparam logic [20:0] OP_BUS = 21'd3 << 17;
    localparam logic [20:0] HLT    = 21'd1 << 19;
    localparam logic [20:0] SEL_PC = 21'd2;
    localparam logic [20:0] SEL_MEM = 21'd7;

    logic        clk, reset;
    logic [20:0] control_reg;
    logic [11:0] mem_rdata, mem_wdata, ir, ac, dr;
    logic [7:0]  mem_addr, pc, ar;
    logic        mem_we, e, ac_zero, halted, cw_err;
    logic [11:0] mem [0:255];
    logic [15:0] wide_instr;

    int checks, errors;
    int m_ar, m_pc, m_dr, m_ac, m_ir, m_e, m_run, m_err;

    mano_datapath #(.WORD_W(12), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .control_reg(control_reg), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .ir(ir),
        .ac(ac), .dr(dr), .pc(pc), .ar(ar), .e(e), .ac_zero(ac_zero),
        .halted(halted), .cw_err(cw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_e = 0; m_err = 0; m_run = 1;
    endtask

    task automatic check_state();
        check_eq("ar", ar, m_ar);
        check_eq("pc", pc, m_pc);
        check_eq("dr", dr, m_dr);
        check_eq("ac", ac, m_ac);
        check_eq("ir", ir, m_ir);
        check_eq("e", e, m_e);
        check_eq("ac_zero", ac_zero, (m_ac == 0) ? 1 : 0);
        check_eq("halted", halted, m_run ? 0 : 1);
        check_eq("cw_err", cw_err, m_err);
    endtask

    // Drive one control word (called at posedge+1), check bus outputs, advance model, check state.
    task automatic step(input logic [20:0] cw);
        int sel, op, busv, aluv, cir_only, cil_only;
        int n_ar, n_pc, n_dr, n_ac, n_ir, n_e;
        control_reg = cw;
        #1;
        sel = int'(cw[2:0]);
        op  = int'(cw[18:17]);
        case (sel)
            1: busv = m_ar;
            2: busv = m_pc;
            3: busv = m_dr;
            4: busv = m_ac;
            5: busv = m_ir;
            7: busv = int'(mem[m_ar]);
            default: busv = 0;
        endcase
        check_eq("mem_addr", mem_addr, m_ar);
        check_eq("mem_wdata", mem_wdata, busv);
        check_eq("mem_we", mem_we, (m_run != 0 && cw[9]) ? 1 : 0);
        case (op)
            0: aluv = m_dr;
            1: aluv = m_ac & m_dr;
            2: aluv = (m_ac + m_dr) % 4096;
            default: aluv = busv;
        endcase
        cir_only = (cw[15] && !cw[16]) ? 1 : 0;
        cil_only = (cw[16] && !cw[15]) ? 1 : 0;
        n_ar = m_ar; n_pc = m_pc; n_dr = m_dr; n_ac = m_ac; n_ir = m_ir; n_e = m_e;
        if (m_run != 0) begin
            if (cw[20]) n_ar = 0; else if (cw[3]) n_ar = busv % 256;
            if (cw[4]) n_pc = busv % 256; else if (cw[5]) n_pc = (m_pc + 1) % 256;
            if (cw[6]) n_dr = busv;
            if (cw[8]) n_ir = busv;
            if (cw[10]) n_ac = 0;
            else if (cw[7]) n_ac = aluv;
            else if (cw[11]) n_ac = (m_ac + 1) % 4096;
            else if (cir_only != 0) n_ac = m_e * 2048 + m_ac / 2;
            else if (cil_only != 0) n_ac = (m_ac * 2) % 4096 + m_e;
            else if (cw[14]) n_ac = 4095 - m_ac;
            if (cw[12]) n_e = 0;
            else if (cw[7] && op == 2) n_e = (m_ac + m_dr) / 4096;
            else if (cir_only != 0) n_e = m_ac % 2;
            else if (cil_only != 0) n_e = m_ac / 2048;
            else if (cw[13]) n_e = 1 - m_e;
            if ((cw[15] && cw[16]) || (cw[9] && sel == 7)) m_err = 1;
            if (cw[19]) m_run = 0;
        end
        m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac; m_ir = n_ir; m_e = n_e;
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Load a value into AC through memory at the current AR.
    task automatic load_ac(input logic [11:0] v);
        mem[m_ar] = v;
        step(SEL_MEM | AC_LD | OP_BUS);
    endtask

    task automatic load_dr(input logic [11:0] v);
        mem[m_ar] = v;
        step(SEL_MEM | DR_LD);
    endtask

    // Asynchronous reset asserted mid-cycle; released at posedge+1.
    task automatic do_reset();
        control_reg = MEM_WE | AR_LD | SEL_PC;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_mem_we", mem_we, 0);
        check_state();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 4095));
        reset = 1'b1;
        control_reg = 21'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-stream with AC = 0xABC
        load_ac(12'hABC);
        check_eq("ac_abc", ac, 12'hABC);
        do_reset();
        check_eq("reset_ac", ac, 0);
        check_eq("reset_halted", halted, 0);

        // Fetch sequence
        mem[0] = 12'h005;
        step(SEL_MEM | PC_LD);
        wide_instr = 16'h7800;
        mem[5] = wide_instr[11:0];
        step(SEL_PC | AR_LD | PC_INC);
        check_eq("fetch_ar", ar, 8'h05);
        check_eq("fetch_pc", pc, 8'h06);
        step(SEL_MEM | IR_LD);
        check_eq("fetch_ir", ir, 12'h800);
        mem[5] = 12'h0FF;
        step(SEL_MEM | PC_LD);
        step(PC_INC);
        check_eq("pc_wrap", pc, 8'h00);

        // ADD with carry, then AND leaves E alone
        load_ac(12'hFFF);
        load_dr(12'h001);
        step(AC_LD | OP_ADD);
        check_eq("add_ac", ac, 12'h000);
        check_eq("add_e", e, 1);
        check_eq("add_zero", ac_zero, 1);
        load_ac(12'hF0F);
        load_dr(12'h0FF);
        step(AC_LD | OP_AND);
        check_eq("and_ac", ac, 12'h00F);
        check_eq("and_e", e, 1);

        // Rotates
        load_ac(12'h801);
        step(E_CLR);
        step(CIR);
        check_eq("cir_ac", ac, 12'h400);
        check_eq("cir_e", e, 1);
        step(CIL);
        check_eq("cil_ac", ac, 12'h801);
        check_eq("cil_e", e, 0);
        check_eq("err_before", cw_err, 0);
        step(CIR | CIL);
        check_eq("both_ac", ac, 12'h801);
        check_eq("both_e", e, 0);
        check_eq("both_err", cw_err, 1);
        step(21'd0);
        check_eq("err_sticky", cw_err, 1);

        // Priorities
        load_ac(12'h123);
        step(AC_CLR | AC_INC | AC_CMP);
        check_eq("prio_ac", ac, 12'h000);
        load_ac(12'hFFF);
        load_dr(12'h001);
        step(AC_LD | OP_ADD | E_CLR);
        check_eq("prio_e", e, 0);

        // Halt
        step(HLT | PC_INC);
        check_eq("hlt_pc", pc, 8'h01);
        check_eq("hlt_halted", halted, 1);
        step(SEL_PC | AR_LD | MEM_WE | PC_INC);
        check_eq("halt_hold_pc", pc, 8'h01);
        step(AC_INC | MEM_WE);
        do_reset();
        check_eq("restart_halted", halted, 0);

        // Randomized control words (no halt until the very end)
        for (int n = 0; n < 400; n++) begin
            step(21'($urandom_range(0, 21'h1FFFFF)) & ~HLT);
            if (n == 200) do_reset();
        end
        step(HLT | 21'($urandom_range(0, 21'h7FFFF)));
        for (int n = 0; n < 10; n++) step(21'($urandom_range(0, 21'h1FFFFF)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
